// File: rtl/probability_table_writer.sv
// probability_table_writer: counts 8-bit symbols per block, then streams a 256-entry probability table.
module probability_table_writer #(
  parameter int BLOCK_LEN = 1024,
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [7:0]  symbol,
  output logic        sym_ready,
  input  logic        block_flush,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ready,
  output logic        table_done
);
  localparam logic [1:0] CLEAR = 2'd0, COUNT = 2'd1, LOAD = 2'd2, EMIT = 2'd3;
  localparam logic [15:0] BLK = 16'(BLOCK_LEN);
  logic [1:0] state;
  logic [15:0] cnt [256];
  logic [7:0] clr_idx;
  logic [15:0] nsym;
  logic acc, fire, last, blk_end, cnt_we;
  logic [15:0] rd_sym, rd_next, cnt_wd;
  logic [7:0] cnt_wa;
  // offset plus shifted count is formed wide so large counts saturate instead of wrapping
  function automatic logic [15:0] prob(input logic [15:0] c);
    logic [31:0] p;
    p = 32'h1000 + (32'(c) << SHIFT);
    return p > 32'hFFFF ? 16'hFFFF : p[15:0];
  endfunction
  always_comb begin
    acc = state == COUNT && sym_valid && sym_ready;
    fire = state == EMIT && wr_valid && wr_ready;
    last = wr_addr == 8'hFF;
    rd_sym = cnt[symbol];
    rd_next = cnt[wr_addr + 8'd1];
    blk_end = acc && (nsym + 16'd1 == BLK);
    cnt_we = state == CLEAR || acc || fire;
    cnt_wa = state == CLEAR ? clr_idx : fire ? wr_addr : symbol;
    cnt_wd = acc ? (rd_sym == 16'hFFFF ? rd_sym : rd_sym + 16'd1) : 16'h0;
  end
  // one shared write port: zeroing in CLEAR, increment in COUNT, clear-after-read in EMIT
  always_ff @(posedge clk)
    if (cnt_we) cnt[cnt_wa] <= cnt_wd;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      clr_idx <= 8'd0;
      nsym <= 16'd0;
      sym_ready <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 16'd0;
      table_done <= 1'b0;
    end else begin
      table_done <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 8'd1;
          if (clr_idx == 8'hFF) begin
            state <= COUNT;
            sym_ready <= 1'b1;
          end
        end
        COUNT: begin
          if (acc) nsym <= nsym + 16'd1;
          if (blk_end || block_flush) begin
            state <= LOAD;
            sym_ready <= 1'b0;
            nsym <= 16'd0;
          end
        end
        LOAD: begin
          wr_addr <= 8'd0;
          wr_data <= prob(cnt[0]);
          wr_valid <= 1'b1;
          state <= EMIT;
        end
        default: begin
          if (fire && last) begin
            wr_valid <= 1'b0;
            table_done <= 1'b1;
            sym_ready <= 1'b1;
            state <= COUNT;
          end else if (fire) begin
            wr_addr <= wr_addr + 8'd1;
            wr_data <= prob(rd_next);
          end
        end
      endcase
    end
  end
endmodule

// File: doc/probability_table_writer.md
# probability_table_writer

Encoder-side counterpart to the entropy decoder's probability lookup in the LiDAR codec. It gathers per-symbol occurrence counts over a block of 8-bit symbols, then streams one 16-bit probability word per table address (0..255) over a valid/ready write port into the decoder-side 256-entry probability table. It sits between the symbol source and the range calculator's probability table, and repopulates that table once per block.

## Interface
- BLOCK_LEN, 1024: symbols per block; range 1..65535.
- SHIFT, 4: left shift applied to a count before the probability offset is added.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- sym_valid  input  1  symbol present.
- symbol  input  8  symbol value.
- sym_ready  output  1  block accepts a symbol; high only in COUNT.
- block_flush  input  1  single-cycle pulse that ends the current block early; honoured only in COUNT.
- wr_valid  output  1  table write pending.
- wr_addr  output  8  table address.
- wr_data  output  16  probability word.
- wr_ready  input  1  table sink accepts the write.
- table_done  output  1  one-cycle pulse after address 255 is accepted.

## Operation
- Count storage: 256 x 16-bit counters, plus a 16-bit block counter `nsym`.
- Counters saturate at 16'hFFFF.
- States:
  - CLEAR: zeroes counters 0..255, one per cycle, for 256 cycles. Then goes to COUNT.
  - COUNT: a symbol is accepted when `sym_valid && sym_ready`. An accepted symbol increments `count[symbol]` and `nsym`.
  - LOAD: one cycle. Registers `wr_data` for address 0 and sets `wr_valid`. Goes to EMIT.
  - EMIT: streams the 256 table writes.
- COUNT exits to LOAD on the edge where `nsym` reaches BLOCK_LEN, or on the edge where `block_flush` is high.
- If a symbol is accepted on the same edge as `block_flush`, the symbol is counted first and the state then goes to LOAD.
- A flush with zero symbols accepted still emits a full table.
- `nsym` clears on entry to LOAD.
- Probability word: `wr_data = min(16'h1000 + (count << SHIFT), 16'hFFFF)`, computed 17+ bits wide and then saturated.
- A zero count gives 16'h1000.
- EMIT, on each write where `wr_valid && wr_ready`:
  - `count[wr_addr]` is cleared.
  - If `wr_addr < 255`: `wr_addr` increments and `wr_data` is loaded from the next counter on the same edge.
  - If `wr_addr == 255`: `wr_valid` drops, `table_done` pulses for one cycle, and the state returns to COUNT. Counters are already zero, so no CLEAR pass runs.
- Backpressure: while `wr_valid && !wr_ready`, `wr_addr` and `wr_data` hold stable.
- Symbols are never accepted outside COUNT.
- `block_flush` is ignored in CLEAR, LOAD and EMIT.

## Timing
- Reset values: `sym_ready`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `table_done`=0, state=CLEAR.
- Reset asserted mid-block or mid-EMIT discards all counts and pending writes. The block restarts at CLEAR.
- After reset deasserts, `sym_ready` rises 256 cycles later.
- `sym_ready` is registered, and drops on the edge that accepts the BLOCK_LEN-th symbol or samples `block_flush`.
- Latency: last symbol accepted or flush sampled at edge k. Then LOAD occupies the cycle after edge k, and `wr_valid` is high with address 0 after edge k+1.
- With `wr_ready` held high, `wr_valid` stays high for exactly 256 consecutive cycles, addresses 0..255 in order.
- `table_done` is high for the cycle after the edge that accepts address 255. `sym_ready` rises on that same edge.
- The count update is single-cycle read-modify-write. Back-to-back repeats of the same symbol are counted correctly.

## Test plan
- Reset then idle.
  - `sym_ready` is low for exactly 256 cycles, then high.
  - All outputs stay at their reset values until then.
- Full block, BLOCK_LEN=1024, SHIFT=4.
  - Stimulus: 1024 copies of symbol 8'h05, `wr_ready`=1.
  - Required: addr 5 gets 16'h5000, every other address gets 16'h1000, 256 contiguous writes, one `table_done` pulse.
- Saturation.
  - Stimulus: BLOCK_LEN=4096, 4096 copies of symbol 8'hFF.
  - Required: addr 255 gets 16'hFFFF, not a wrapped value.
- Flush edge cases.
  - Flush with 0 symbols: all 256 writes are 16'h1000.
  - Flush on the same cycle as accepted symbol 8'h10 (SHIFT=4): addr 16 gets 16'h1010.
- Backpressure.
  - Stimulus: toggle `wr_ready` pseudo-randomly during EMIT.
  - Required: `wr_addr`/`wr_data` stable while stalled, no address skipped or repeated.
  - Second block: counts start from zero, with no residue from the first block.
- Reset mid-EMIT at addr 100.
  - Required: `wr_valid` drops immediately and CLEAR runs 256 cycles.
  - A new 1-symbol flushed block (symbol 8'h00) gives addr 0 = 16'h1010, all others 16'h1000.
